// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Saturating increment for the optional statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with per-byte-lane write enables and a registered read port.
// Contents are never reset; reads return the word addressed on the previous clock edge.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [AW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Byte-lane write and registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data load/store port. Accepts one request at a
// time, waits LATENCY cycles, commits the access and holds the response until taken.
// Optional statistics outputs are built when DMEM_STATS_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_rd_cnt,
    output logic [STAT_W-1:0] stat_wr_cnt,
    output logic [STAT_W-1:0] stat_err_cnt
`endif
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int ARR_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [IDX_W-1:0] DEPTH_LIM = IDX_W'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAT_INIT  = CNT_W'(LATENCY);

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;

    logic [IDX_W-1:0]  word_idx;
    logic              commit;
    logic              commit_err;
    logic              arr_we;
    logic [ARR_AW-1:0] arr_idx;
    logic [WORD_W-1:0] arr_rdata;

    // The commit edge is the one that leaves WAIT with the counter already at zero.
    // A zero-latency request spends exactly one cycle in WAIT, which gives the
    // registered array read the cycle it needs before the response is loaded.
    assign word_idx   = addr_q[ADDR_W-1:2];
    assign commit_err = (addr_q[1:0] != 2'b00) || (word_idx >= DEPTH_LIM);
    assign commit     = (state == WAIT) && (wait_cnt == '0);
    assign arr_we     = commit && we_q && !commit_err;

    // In IDLE the array is addressed straight from the request so the read launched on
    // the accept edge is already valid when a zero-latency request commits.
    assign arr_idx = (state == IDLE) ? req_addr[ARR_AW+1:2] : addr_q[ARR_AW+1:2];

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (ARR_AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (be_q),
        .idx   (arr_idx),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    // Request/wait/response sequencing with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        be_q      <= req_be;
                        wait_cnt  <= LAT_INIT;
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (commit) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= commit_err;
                        rsp_rdata <= (commit_err || we_q) ? '0 : arr_rdata;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_STATS_EN
    // Count committed loads, stores and errors, each saturating at full scale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_rd_cnt  <= '0;
            stat_wr_cnt  <= '0;
            stat_err_cnt <= '0;
        end else if (commit) begin
            if (commit_err) begin
                stat_err_cnt <= sat_inc(stat_err_cnt);
            end else if (we_q) begin
                stat_wr_cnt <= sat_inc(stat_wr_cnt);
            end else begin
                stat_rd_cnt <= sat_inc(stat_rd_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 0) driven by directed and
// random transactions, checked every cycle against a transaction-level model.
module tb_dmem_responder;

    localparam int NDUT  = 2;
    localparam int DEPTH = 1024;
    localparam int LAT0  = 2;
    localparam int LAT1  = 0;
    localparam int TMO   = 100;

    logic        clk = 1'b0;
    logic        rst       [NDUT];
    logic        req_valid [NDUT];
    logic        req_ready [NDUT];
    logic        req_we    [NDUT];
    logic [31:0] req_addr  [NDUT];
    logic [31:0] req_wdata [NDUT];
    logic [3:0]  req_be    [NDUT];
    logic        rsp_valid [NDUT];
    logic        rsp_ready [NDUT];
    logic [31:0] rsp_rdata [NDUT];
    logic        rsp_err   [NDUT];
`ifdef DMEM_STATS_EN
    logic [15:0] stat_rd  [NDUT];
    logic [15:0] stat_wr  [NDUT];
    logic [15:0] stat_er  [NDUT];
    int          m_nrd    [NDUT];
    int          m_nwr    [NDUT];
    int          m_ner    [NDUT];
`endif

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0), .ADDR_W(32)) dut0 (
        .clk       (clk),
        .rst       (rst[0]),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_we    (req_we[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .req_be    (req_be[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_err   (rsp_err[0])
`ifdef DMEM_STATS_EN
        ,
        .stat_rd_cnt  (stat_rd[0]),
        .stat_wr_cnt  (stat_wr[0]),
        .stat_err_cnt (stat_er[0])
`endif
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1), .ADDR_W(32)) dut1 (
        .clk       (clk),
        .rst       (rst[1]),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_we    (req_we[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .req_be    (req_be[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_err   (rsp_err[1])
`ifdef DMEM_STATS_EN
        ,
        .stat_rd_cnt  (stat_rd[1]),
        .stat_wr_cnt  (stat_wr[1]),
        .stat_err_cnt (stat_er[1])
`endif
    );

    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    task automatic check_output(input string name, input int d, input logic [31:0] got,
                                input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s dut%0d: got %h, want %h", name, d, got, exp);
        end
    endtask

    // Transaction-level model: one outstanding request whose response appears
    // LATENCY+1 edges after acceptance and retires on the first edge with rsp_ready.
    bit          m_busy      [NDUT];
    bit          m_resp      [NDUT];
    int          m_commit_at [NDUT];
    bit          m_we        [NDUT];
    logic [31:0] m_addr      [NDUT];
    logic [31:0] m_wdata     [NDUT];
    logic [3:0]  m_be        [NDUT];
    logic [31:0] m_rdata     [NDUT];
    bit          m_err       [NDUT];
    logic [31:0] m_mem       [NDUT][DEPTH];
    int          cyc = 0;

    // Advance the model on every rising edge using the inputs the bench applied.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < NDUT; d++) begin
            if (!rst[d]) begin
                m_busy[d] = 1'b0;
                m_resp[d] = 1'b0;
`ifdef DMEM_STATS_EN
                m_nrd[d] = 0;
                m_nwr[d] = 0;
                m_ner[d] = 0;
`endif
            end else if (!m_busy[d]) begin
                if (req_valid[d]) begin
                    m_busy[d]      = 1'b1;
                    m_we[d]        = req_we[d];
                    m_addr[d]      = req_addr[d];
                    m_wdata[d]     = req_wdata[d];
                    m_be[d]        = req_be[d];
                    m_commit_at[d] = cyc + lat_of(d) + 1;
                end
            end else if (!m_resp[d]) begin
                if (cyc == m_commit_at[d]) begin
                    int unsigned widx;
                    widx     = m_addr[d] >> 2;
                    m_err[d] = (m_addr[d] % 4 != 0) || (widx >= DEPTH);
                    m_rdata[d] = 32'h0;
                    if (!m_err[d]) begin
                        if (m_we[d]) begin
                            for (int i = 0; i < 4; i++)
                                if (m_be[d][i]) m_mem[d][widx][8*i +: 8] = m_wdata[d][8*i +: 8];
                        end else begin
                            m_rdata[d] = m_mem[d][widx];
                        end
                    end
`ifdef DMEM_STATS_EN
                    if (m_err[d]) m_ner[d]++;
                    else if (m_we[d]) m_nwr[d]++;
                    else m_nrd[d]++;
`endif
                    m_resp[d] = 1'b1;
                end
            end else if (rsp_ready[d]) begin
                m_busy[d] = 1'b0;
                m_resp[d] = 1'b0;
            end
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            for (int d = 0; d < NDUT; d++) begin
                bit          e_ready, e_valid, e_err;
                logic [31:0] e_rdata;
                if (!rst[d]) begin
                    e_ready = 1'b1; e_valid = 1'b0; e_rdata = 32'h0; e_err = 1'b0;
                end else begin
                    e_ready = !m_busy[d];
                    e_valid = m_resp[d];
                    e_rdata = m_resp[d] ? m_rdata[d] : 32'h0;
                    e_err   = m_resp[d] && m_err[d];
                end
                check_output("req_ready", d, 32'(req_ready[d]), 32'(e_ready));
                check_output("rsp_valid", d, 32'(rsp_valid[d]), 32'(e_valid));
                check_output("rsp_rdata", d, rsp_rdata[d], e_rdata);
                check_output("rsp_err",   d, 32'(rsp_err[d]),   32'(e_err));
`ifdef DMEM_STATS_EN
                check_output("stat_rd",  d, 32'(stat_rd[d]), rst[d] ? 32'((m_nrd[d] > 65535) ? 65535 : m_nrd[d]) : 32'h0);
                check_output("stat_wr",  d, 32'(stat_wr[d]), rst[d] ? 32'((m_nwr[d] > 65535) ? 65535 : m_nwr[d]) : 32'h0);
                check_output("stat_err", d, 32'(stat_er[d]), rst[d] ? 32'((m_ner[d] > 65535) ? 65535 : m_ner[d]) : 32'h0);
`endif
            end
        end
    end

    // Issue one request and take its response; called 2 time units after a rising edge.
    task automatic apply_stimulus(input int d, input bit we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be,
                                  input int hold, input bit noisy, output int lat,
                                  output logic [31:0] rdata, output logic err);
        int t;
        req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_be[d] = be;
        req_valid[d] = 1'b1;
        t = 0;
        while (!req_ready[d] && t < TMO) begin
            @(posedge clk); #2; t++;
        end
        if (t >= TMO) check_output("accept_timeout", d, 32'(t), 32'(0));
        @(posedge clk); #2;
        lat = 0;
        while (!rsp_valid[d] && lat < TMO) begin
            if (noisy) begin
                req_valid[d] = 1'($urandom); req_we[d] = 1'($urandom);
                req_addr[d]  = $urandom;     req_wdata[d] = $urandom;
                req_be[d]    = 4'($urandom); rsp_ready[d] = 1'($urandom);
            end else begin
                req_valid[d] = 1'b0;
            end
            @(posedge clk); #2; lat++;
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b0;
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        check_output("rsp_latency", d, 32'(lat), 32'(lat_of(d) + 1));
        repeat (hold) begin
            @(posedge clk); #2;
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk); #2;
        rsp_ready[d] = 1'b0;
        check_output("idle_after_rsp", d, 32'(req_ready[d]), 32'd1);
    endtask

    task automatic store_chk(input int d, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] be, input logic exp_err);
        int lat; logic [31:0] rd; logic er;
        apply_stimulus(d, 1'b1, addr, data, be, 0, 1'b0, lat, rd, er);
        check_output("store_rdata", d, rd, 32'h0);
        check_output("store_err", d, 32'(er), 32'(exp_err));
    endtask

    task automatic load_chk(input int d, input logic [31:0] addr, input logic [31:0] exp_d,
                            input logic exp_err, input int hold);
        int lat; logic [31:0] rd; logic er;
        apply_stimulus(d, 1'b0, addr, 32'h0, 4'hF, hold, 1'b0, lat, rd, er);
        check_output("load_rdata", d, rd, exp_d);
        check_output("load_err", d, 32'(er), 32'(exp_err));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat; logic [31:0] rd; logic er; logic [31:0] addr; int k;
        for (int d = 0; d < NDUT; d++) begin
            rst[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; req_be[d] = '0; rsp_ready[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check_output("reset_req_ready", d, 32'(req_ready[d]), 32'd1);
            check_output("reset_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
            check_output("reset_rsp_rdata", d, rsp_rdata[d], 32'h0);
            check_output("reset_rsp_err",   d, 32'(rsp_err[d]), 32'd0);
        end
        @(posedge clk); #2;
        rst[0] = 1'b1; rst[1] = 1'b1;
        check_en = 1'b1;

        $display("[TB] directed sequence, LATENCY=2");
        store_chk(0, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1'b0);
        store_chk(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
        load_chk (0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 0);
        store_chk(0, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b0);
        store_chk(0, 32'h0000_0020, 32'h0000_00AA, 4'b0001, 1'b0);
        load_chk (0, 32'h0000_0020, 32'h1122_33AA, 1'b0, 0);
        load_chk (0, 32'h0000_0006, 32'h0000_0000, 1'b1, 0);
        store_chk(0, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 1'b1);
        load_chk (0, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 0);
        load_chk (0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 5);
        store_chk(0, 32'h0000_0010, 32'h0000_0000, 4'h0, 1'b0);
        load_chk (0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 0);

        $display("[TB] reset during a pending store");
        store_chk(0, 32'h0000_0030, 32'h5555_5555, 4'hF, 1'b0);
        req_we[0] = 1'b1; req_addr[0] = 32'h30; req_wdata[0] = 32'hFFFF_FFFF;
        req_be[0] = 4'hF; req_valid[0] = 1'b1;
        @(posedge clk); #2;
        req_valid[0] = 1'b0;
        @(posedge clk); #2;
        rst[0] = 1'b0;
        #1;
        check_output("midreset_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
        check_output("midreset_req_ready", 0, 32'(req_ready[0]), 32'd1);
        @(posedge clk); #2;
        rst[0] = 1'b1;
        load_chk(0, 32'h0000_0030, 32'h5555_5555, 1'b0, 0);

        $display("[TB] directed sequence, LATENCY=0");
        store_chk(1, 32'h0000_0040, 32'hA5A5_A5A5, 4'hF, 1'b0);
        load_chk (1, 32'h0000_0040, 32'hA5A5_A5A5, 1'b0, 0);
        store_chk(1, 32'h0000_0040, 32'h0000_7700, 4'b0010, 1'b0);
        load_chk (1, 32'h0000_0040, 32'hA5A5_77A5, 1'b0, 0);
        load_chk (1, 32'h0000_0007, 32'h0000_0000, 1'b1, 2);

        $display("[TB] random traffic against the model");
        for (int d = 0; d < NDUT; d++) begin
            for (int w = 0; w < 16; w++)
                apply_stimulus(d, 1'b1, 32'(w) << 2, $urandom, 4'hF, 0, 1'b0, lat, rd, er);
            for (int n = 0; n < 60; n++) begin
                k = $urandom_range(0, 19);
                if (k < 14)      addr = 32'($urandom_range(0, 15)) << 2;
                else if (k < 17) addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
                else             addr = 32'($urandom_range(1024, 1000000)) << 2;
                apply_stimulus(d, 1'($urandom), addr, $urandom, 4'($urandom),
                               $urandom_range(0, 3), 1'b1, lat, rd, er);
            end
        end

        repeat (2) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
